pipeline_hazard_ctrl: RTL



---
 rtl/pipeline_hazard_ctrl.sv | 130 +++++++++++++
 1 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard sequencer for the IF/ID and ID/EX stage registers: load-use bubbles, redirect flushes,
// data-memory wait freezes and ALU forwarding selects. Optional perf counters: HAZARD_PERF_CNT_EN.
module pipeline_hazard_ctrl #(
  parameter int LOAD_USE_STALLS = 1,
  parameter int REG_ADDR_W      = 5
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_reg_write,
  input  logic                  ex_is_load,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  mem_reg_write,
  input  logic                  ex_redirect,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  output logic                  pc_en,
  output logic                  ifid_en,
  output logic                  ifid_flush,
  output logic                  idex_en,
  output logic                  idex_flush,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic [1:0]            state
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]           stall_cycles,
  output logic [31:0]           flush_events
`endif
);

  typedef enum logic [1:0] {RUN = 2'b00, LSTALL = 2'b01, MWAIT = 2'b10} state_t;

  localparam logic [1:0] LUS_M1 = 2'(LOAD_USE_STALLS - 1);

  state_t     r_state, w_nstate;
  logic [1:0] r_cnt, w_ncnt;
  logic       w_lu, w_lstall_mode, w_redir;
  logic       w_pc_en, w_ifid_en, w_ifid_flush, w_idex_en, w_idex_flush;
  logic [1:0] w_fwd_a, w_fwd_b;

  assign w_lu = ex_is_load && ex_reg_write && (ex_rd != '0) &&
                ((id_uses_rs1 && (id_rs1 == ex_rd)) || (id_uses_rs2 && (id_rs2 == ex_rd)));

  // After a memory wait, a non-zero counter means the load-use bubble train resumes.
  assign w_lstall_mode = (r_state == LSTALL) || ((r_state == MWAIT) && (r_cnt != 2'd0));

  always_comb begin
    w_pc_en      = 1'b1;
    w_ifid_en    = 1'b1;
    w_ifid_flush = 1'b0;
    w_idex_en    = 1'b1;
    w_idex_flush = 1'b0;
    w_redir      = 1'b0;
    w_nstate     = RUN;
    w_ncnt       = r_cnt;
    if (((r_state == MWAIT) && !mem_ready) ||
        ((r_state != MWAIT) && mem_req && !mem_ready)) begin
      w_pc_en   = 1'b0;
      w_ifid_en = 1'b0;
      w_idex_en = 1'b0;
      w_nstate  = MWAIT;
    end else if (ex_redirect) begin
      w_ifid_flush = 1'b1;
      w_idex_flush = 1'b1;
      w_redir      = 1'b1;
      w_ncnt       = 2'd0;
    end else if (w_lstall_mode) begin
      w_pc_en      = 1'b0;
      w_ifid_en    = 1'b0;
      w_idex_flush = 1'b1;
      w_ncnt       = r_cnt - 2'd1;
      w_nstate     = (r_cnt == 2'd1) ? RUN : LSTALL;
    end else if (w_lu) begin
      w_pc_en      = 1'b0;
      w_ifid_en    = 1'b0;
      w_idex_flush = 1'b1;
      if (LOAD_USE_STALLS > 1) begin
        w_ncnt   = LUS_M1;
        w_nstate = LSTALL;
      end
    end
  end

  // EX result wins over MEM; a load in EX has no result to forward yet.
  always_comb begin
    w_fwd_a = 2'b00;
    w_fwd_b = 2'b00;
    if (ex_reg_write && !ex_is_load && (ex_rd != '0) && (ex_rd == id_rs1)) w_fwd_a = 2'b01;
    else if (mem_reg_write && (mem_rd != '0) && (mem_rd == id_rs1))        w_fwd_a = 2'b10;
    if (ex_reg_write && !ex_is_load && (ex_rd != '0) && (ex_rd == id_rs2)) w_fwd_b = 2'b01;
    else if (mem_reg_write && (mem_rd != '0) && (mem_rd == id_rs2))        w_fwd_b = 2'b10;
  end

  assign pc_en      = RST ? 1'b0  : w_pc_en;
  assign ifid_en    = RST ? 1'b0  : w_ifid_en;
  assign ifid_flush = RST ? 1'b1  : w_ifid_flush;
  assign idex_en    = RST ? 1'b1  : w_idex_en;
  assign idex_flush = RST ? 1'b1  : w_idex_flush;
  assign fwd_a      = RST ? 2'b00 : w_fwd_a;
  assign fwd_b      = RST ? 2'b00 : w_fwd_b;
  assign state      = RST ? 2'b00 : r_state;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= RUN;
      r_cnt   <= 2'd0;
    end else begin
      r_state <= w_nstate;
      r_cnt   <= w_ncnt;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cycles <= 32'd0;
      flush_events <= 32'd0;
    end else begin
      stall_cycles <= stall_cycles + {31'd0, !w_pc_en};
      flush_events <= flush_events + {31'd0, w_redir};
    end
  end
`endif

endmodule
